// File: rtl/trainer_pkg.sv
// Shared definitions for the digital logic trainer: gate and mode encodings,
// the quiz state enum, LFSR constants and the score ceiling.
package trainer_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_NOT_A  = 3'b010,
        OP_NAND   = 3'b011,
        OP_NOR    = 3'b100,
        OP_XOR    = 3'b101,
        OP_XNOR   = 3'b110,
        OP_RSVD   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        MODE_LIVE  = 2'b00,
        MODE_SWEEP = 2'b01,
        MODE_QUIZ  = 2'b10,
        MODE_ALT   = 2'b11
    } mode_e;

    typedef enum logic {
        Q_PRESENT = 1'b0,
        Q_JUDGE   = 1'b1
    } quiz_state_e;

    // x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register: taps on bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] SCORE_MAX = 8'd255;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/digital_trainer_core_if.sv
// Student-facing signal bundle of the trainer core. The driver side (wrapper or
// bench) uses the master modport, the core uses the slave modport.
interface digital_trainer_core_if #(
    parameter int W = 4
);
    logic         ena;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic [1:0]   mode;
    logic         step;
    logic         check;
    logic [W-1:0] ans;
    logic [W-1:0] disp_a;
    logic [W-1:0] disp_b;
    logic [W-1:0] y;
    logic         correct;
    logic         wrong;
    logic [7:0]   score;

    modport master (
        output ena, a, b, sel, mode, step, check, ans,
        input  disp_a, disp_b, y, correct, wrong, score
    );

    modport slave (
        input  ena, a, b, sel, mode, step, check, ans,
        output disp_a, disp_b, y, correct, wrong, score
    );
endinterface

// File: rtl/trainer_alu.sv
// Combinational W-bit gate evaluator; reserved select yields zero.
module trainer_alu
    import trainer_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res
);

    // Bitwise gate selected by op
    always_comb begin
        res = '0;
        case (op_e'(op))
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_NOT_A: res = ~a;
            OP_NAND:  res = ~(a & b);
            OP_NOR:   res = ~(a | b);
            OP_XOR:   res = a ^ b;
            OP_XNOR:  res = ~(a ^ b);
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/digital_trainer_core.sv
// Digital logic trainer core: LIVE, SWEEP and QUIZ gate-exercise modes.
// Optional feature macro: TRAINER_QUIZ_EN builds QUIZ mode (LFSR, judge FSM,
// score and verdict pulses); without it mode 10 acts as LIVE and the quiz
// outputs are tied low.
module digital_trainer_core
    import trainer_pkg::*;
#(
    parameter int W        = 4,
    parameter int STEP_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digital_trainer_core_if.slave bus
);

    localparam int            PW     = $clog2(STEP_DIV);
    localparam logic [PW-1:0] PRE_TC = PW'(STEP_DIV - 1);

    mode_e          mode_eff;
    logic           mode_chg;
    logic           step_edge;
    logic [W-1:0]   src_a;
    logic [W-1:0]   src_b;
    logic [W-1:0]   alu_y;
    logic [W-1:0]   quiz_a;
    logic [W-1:0]   quiz_b;

    logic           step_prev_q, step_prev_d;
    logic [1:0]     mode_q, mode_d;
    logic [2*W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [W-1:0]   y_q, y_d;

    // Effective mode: 11 (and 10 when QUIZ is not built) fall back to LIVE
    always_comb begin
        mode_eff = MODE_LIVE;
        case (bus.mode)
            2'b01:   mode_eff = MODE_SWEEP;
`ifdef TRAINER_QUIZ_EN
            2'b10:   mode_eff = MODE_QUIZ;
`endif
            default: mode_eff = MODE_LIVE;
        endcase
    end

    assign mode_chg  = (mode_eff != mode_e'(mode_q));
    assign step_edge = bus.step & ~step_prev_q;

    // Operand source mux; held at zero while reset is asserted
    always_comb begin
        src_a = bus.a;
        src_b = bus.b;
        case (mode_eff)
            MODE_SWEEP: begin
                src_a = cnt_q[2*W-1:W];
                src_b = cnt_q[W-1:0];
            end
            MODE_QUIZ: begin
                src_a = quiz_a;
                src_b = quiz_b;
            end
            default: begin
                src_a = bus.a;
                src_b = bus.b;
            end
        endcase
    end

    assign bus.disp_a = rst_n ? src_a : '0;
    assign bus.disp_b = rst_n ? src_b : '0;

    trainer_alu #(.W(W)) u_alu_y (
        .op  (bus.sel),
        .a   (bus.disp_a),
        .b   (bus.disp_b),
        .res (alu_y)
    );

    // Shared next-state: button history, mode tracking, sweep counter, result register
    always_comb begin
        step_prev_d = step_prev_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        y_d         = y_q;
        if (bus.ena) begin
            step_prev_d = bus.step;
            mode_d      = mode_eff;
            y_d         = (mode_eff == MODE_QUIZ) ? '0 : alu_y;
            if (mode_chg) begin
                cnt_d = '0;
                pre_d = '0;
            end else if (mode_eff == MODE_SWEEP) begin
                // A manual step at the terminal count still yields a single increment
                if (step_edge || (pre_q == PRE_TC)) begin
                    cnt_d = cnt_q + (2*W)'(1);
                    pre_d = '0;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        end
    end

    // Shared state registers; reset takes priority over the enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_prev_q <= 1'b0;
            mode_q      <= MODE_LIVE;
            cnt_q       <= '0;
            pre_q       <= '0;
            y_q         <= '0;
        end else begin
            step_prev_q <= step_prev_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            y_q         <= y_d;
        end
    end

    assign bus.y = bus.ena ? y_q : '0;

`ifdef TRAINER_QUIZ_EN
    logic           check_edge;
    logic [W-1:0]   quiz_ref;
    logic           check_prev_q, check_prev_d;
    logic [7:0]     lfsr_q, lfsr_d;
    quiz_state_e    state_q, state_d;
    logic           match_q, match_d;
    logic [7:0]     score_q, score_d;

    assign check_edge = bus.check & ~check_prev_q;
    assign quiz_a     = lfsr_q[2*W-1:W];
    assign quiz_b     = lfsr_q[W-1:0];

    trainer_alu #(.W(W)) u_alu_ref (
        .op  (bus.sel),
        .a   (bus.disp_a),
        .b   (bus.disp_b),
        .res (quiz_ref)
    );

    // Quiz FSM: PRESENT waits for check/skip, JUDGE scores and draws the next question
    always_comb begin
        check_prev_d = check_prev_q;
        lfsr_d       = lfsr_q;
        state_d      = state_q;
        match_d      = match_q;
        score_d      = score_q;
        if (bus.ena) begin
            check_prev_d = bus.check;
            if (mode_chg) begin
                state_d = Q_PRESENT;
                if (mode_eff == MODE_QUIZ) begin
                    score_d = '0;
                end
            end else if (mode_eff == MODE_QUIZ) begin
                case (state_q)
                    Q_PRESENT: begin
                        if (check_edge) begin
                            state_d = Q_JUDGE;
                            match_d = (bus.ans == quiz_ref);
                        end else if (step_edge) begin
                            lfsr_d = lfsr_next(lfsr_q);
                        end
                    end
                    default: begin
                        state_d = Q_PRESENT;
                        lfsr_d  = lfsr_next(lfsr_q);
                        if (match_q && (score_q != SCORE_MAX)) begin
                            score_d = score_q + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Quiz state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            check_prev_q <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            state_q      <= Q_PRESENT;
            match_q      <= 1'b0;
            score_q      <= '0;
        end else begin
            check_prev_q <= check_prev_d;
            lfsr_q       <= lfsr_d;
            state_q      <= state_d;
            match_q      <= match_d;
            score_q      <= score_d;
        end
    end

    assign bus.correct = rst_n && bus.ena && !mode_chg && (state_q == Q_JUDGE) &&  match_q;
    assign bus.wrong   = rst_n && bus.ena && !mode_chg && (state_q == Q_JUDGE) && !match_q;
    assign bus.score   = score_q;
`else
    assign quiz_a      = '0;
    assign quiz_b      = '0;
    assign bus.correct = 1'b0;
    assign bus.wrong   = 1'b0;
    assign bus.score   = '0;
`endif

endmodule

// File: tb/tb_digital_trainer_core.sv
// Directed bench for digital_trainer_core: a W=4 instance for LIVE/QUIZ and a
// W=2, STEP_DIV=4 instance for SWEEP. QUIZ expectations apply when
// TRAINER_QUIZ_EN is defined; otherwise mode 10 is expected to act as LIVE.
module tb_digital_trainer_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    digital_trainer_core_if #(.W(4)) bus4 ();
    digital_trainer_core_if #(.W(2)) bus2 ();

    digital_trainer_core #(.W(4), .STEP_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    digital_trainer_core #(.W(2), .STEP_DIV(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus4.ena = 1'b1; bus4.mode = 2'b00; bus4.a = 4'h3; bus4.b = 4'h5; bus4.sel = 3'b001;
        tick(); tick();
        n_checks++; if (bus4.y !== 4'h0) begin n_fail++; $display("FAIL reset_y: got %h expected 0", bus4.y); end
        n_checks++; if ({bus4.disp_a, bus4.disp_b} !== 8'h00) begin n_fail++; $display("FAIL reset_disp: got %h expected 00", {bus4.disp_a, bus4.disp_b}); end
        n_checks++; if (bus4.score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", bus4.score); end
        n_checks++; if ({bus4.correct, bus4.wrong} !== 2'b00) begin n_fail++; $display("FAIL reset_verdict: got %b expected 00", {bus4.correct, bus4.wrong}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_live();
        logic [3:0] exp_live [8];
        exp_live = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0000};
        bus4.mode = 2'b00; bus4.a = 4'b1100; bus4.b = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            bus4.sel = 3'(i);
            tick();
            n_checks++; if (bus4.y !== exp_live[i]) begin n_fail++; $display("FAIL live_sel%0d: got %b expected %b", i, bus4.y, exp_live[i]); end
        end
        n_checks++; if ({bus4.disp_a, bus4.disp_b} !== 8'hCA) begin n_fail++; $display("FAIL live_disp: got %h expected CA", {bus4.disp_a, bus4.disp_b}); end
        bus4.mode = 2'b11; bus4.sel = 3'b101;
        tick();
        n_checks++; if (bus4.y !== 4'b0110) begin n_fail++; $display("FAIL mode11_live: got %b expected 0110", bus4.y); end
        bus4.mode = 2'b00;
        tick();
    endtask

    task automatic test_sweep();
        logic [3:0] k4;
        logic [3:0] prev;
        bus2.ena = 1'b1; bus2.sel = 3'b000; bus2.mode = 2'b01;
        tick();
        n_checks++; if ({bus2.disp_a, bus2.disp_b} !== 4'h0) begin n_fail++; $display("FAIL sweep_start: got %h expected 0", {bus2.disp_a, bus2.disp_b}); end
        for (int k = 1; k <= 16; k++) begin
            repeat (4) tick();
            k4 = 4'(k);
            prev = 4'(k - 1);
            n_checks++; if ({bus2.disp_a, bus2.disp_b} !== k4) begin n_fail++; $display("FAIL sweep_cnt%0d: got %h expected %h", k, {bus2.disp_a, bus2.disp_b}, k4); end
            n_checks++; if (bus2.y !== (prev[3:2] & prev[1:0])) begin n_fail++; $display("FAIL sweep_y%0d: got %b expected %b", k, bus2.y, prev[3:2] & prev[1:0]); end
        end
        // prescaler now 0 after the wrap: bring it to its terminal count
        repeat (3) tick();
        bus2.step = 1'b1;
        tick();
        n_checks++; if ({bus2.disp_a, bus2.disp_b} !== 4'h1) begin n_fail++; $display("FAIL sweep_step_tc: got %h expected 1", {bus2.disp_a, bus2.disp_b}); end
        bus2.step = 1'b0;
        tick(); tick();
        bus2.step = 1'b1;
        tick();
        n_checks++; if ({bus2.disp_a, bus2.disp_b} !== 4'h2) begin n_fail++; $display("FAIL sweep_step_mid: got %h expected 2", {bus2.disp_a, bus2.disp_b}); end
        bus2.step = 1'b0;
        repeat (3) tick();
        n_checks++; if ({bus2.disp_a, bus2.disp_b} !== 4'h2) begin n_fail++; $display("FAIL sweep_prescale_restart: got %h expected 2", {bus2.disp_a, bus2.disp_b}); end
        tick();
        n_checks++; if ({bus2.disp_a, bus2.disp_b} !== 4'h3) begin n_fail++; $display("FAIL sweep_after_restart: got %h expected 3", {bus2.disp_a, bus2.disp_b}); end
        bus2.ena = 1'b0;
        repeat (10) tick();
        n_checks++; if ({bus2.disp_a, bus2.disp_b} !== 4'h3) begin n_fail++; $display("FAIL sweep_ena_hold: got %h expected 3", {bus2.disp_a, bus2.disp_b}); end
        n_checks++; if (bus2.y !== 2'b00) begin n_fail++; $display("FAIL sweep_ena_y: got %b expected 00", bus2.y); end
        bus2.ena = 1'b1;
        bus2.mode = 2'b00;
        tick();
    endtask

`ifdef TRAINER_QUIZ_EN
    task automatic test_quiz();
        bus4.mode = 2'b10; bus4.sel = 3'b101; bus4.ans = 4'hF; bus4.check = 1'b0; bus4.step = 1'b0;
        tick();
        n_checks++; if ({bus4.disp_a, bus4.disp_b} !== 8'hA5) begin n_fail++; $display("FAIL quiz_seed_disp: got %h expected A5", {bus4.disp_a, bus4.disp_b}); end
        n_checks++; if (bus4.y !== 4'h0) begin n_fail++; $display("FAIL quiz_y_hidden: got %h expected 0", bus4.y); end
        bus4.check = 1'b1;
        tick();
        n_checks++; if ({bus4.correct, bus4.wrong} !== 2'b10) begin n_fail++; $display("FAIL quiz_correct_pulse: got %b expected 10", {bus4.correct, bus4.wrong}); end
        n_checks++; if (bus4.score !== 8'd0) begin n_fail++; $display("FAIL quiz_score_early: got %0d expected 0", bus4.score); end
        bus4.check = 1'b0;
        tick();
        n_checks++; if (bus4.score !== 8'd1) begin n_fail++; $display("FAIL quiz_score_inc: got %0d expected 1", bus4.score); end
        n_checks++; if ({bus4.disp_a, bus4.disp_b} !== 8'h4A) begin n_fail++; $display("FAIL quiz_next_disp: got %h expected 4A", {bus4.disp_a, bus4.disp_b}); end
        n_checks++; if ({bus4.correct, bus4.wrong} !== 2'b00) begin n_fail++; $display("FAIL quiz_pulse_width: got %b expected 00", {bus4.correct, bus4.wrong}); end
        // 4 ^ A = E, so 0 is wrong
        bus4.ans = 4'h0; bus4.check = 1'b1;
        tick();
        n_checks++; if ({bus4.correct, bus4.wrong} !== 2'b01) begin n_fail++; $display("FAIL quiz_wrong_pulse: got %b expected 01", {bus4.correct, bus4.wrong}); end
        bus4.check = 1'b0;
        tick();
        n_checks++; if (bus4.score !== 8'd1) begin n_fail++; $display("FAIL quiz_wrong_score: got %0d expected 1", bus4.score); end
        n_checks++; if ({bus4.disp_a, bus4.disp_b} !== 8'h95) begin n_fail++; $display("FAIL quiz_wrong_disp: got %h expected 95", {bus4.disp_a, bus4.disp_b}); end
        bus4.step = 1'b1;
        tick();
        n_checks++; if ({bus4.disp_a, bus4.disp_b} !== 8'h2A) begin n_fail++; $display("FAIL quiz_skip_disp: got %h expected 2A", {bus4.disp_a, bus4.disp_b}); end
        n_checks++; if ({bus4.correct, bus4.wrong} !== 2'b00) begin n_fail++; $display("FAIL quiz_skip_pulse: got %b expected 00", {bus4.correct, bus4.wrong}); end
        bus4.step = 1'b0;
        tick();
        // check and step together: check wins, 2 ^ A = 8
        bus4.ans = 4'h8; bus4.check = 1'b1; bus4.step = 1'b1;
        tick();
        n_checks++; if ({bus4.correct, bus4.disp_a, bus4.disp_b} !== 9'h12A) begin n_fail++; $display("FAIL quiz_check_wins: got %h expected 12A", {bus4.correct, bus4.disp_a, bus4.disp_b}); end
        bus4.check = 1'b0; bus4.step = 1'b0;
        tick();
        n_checks++; if ({bus4.score, bus4.disp_a, bus4.disp_b} !== 16'h0254) begin n_fail++; $display("FAIL quiz_check_wins_after: got %h expected 0254", {bus4.score, bus4.disp_a, bus4.disp_b}); end
    endtask

    task automatic test_score_saturation();
        // reserved select always expects 0
        bus4.sel = 3'b111; bus4.ans = 4'h0;
        for (int i = 0; i < 253; i++) begin
            bus4.check = 1'b1; tick();
            bus4.check = 1'b0; tick();
        end
        n_checks++; if (bus4.score !== 8'd255) begin n_fail++; $display("FAIL score_reach_255: got %0d expected 255", bus4.score); end
        bus4.check = 1'b1; tick();
        n_checks++; if (bus4.correct !== 1'b1) begin n_fail++; $display("FAIL score_sat_pulse: got %b expected 1", bus4.correct); end
        bus4.check = 1'b0; tick();
        n_checks++; if (bus4.score !== 8'd255) begin n_fail++; $display("FAIL score_hold_255: got %0d expected 255", bus4.score); end
        bus4.mode = 2'b00; tick();
        n_checks++; if (bus4.score !== 8'd255) begin n_fail++; $display("FAIL score_kept_live: got %0d expected 255", bus4.score); end
        bus4.mode = 2'b10; tick();
        n_checks++; if (bus4.score !== 8'd0) begin n_fail++; $display("FAIL score_clear_enter: got %0d expected 0", bus4.score); end
    endtask

    task automatic test_reset_mid_judge();
        bus4.check = 1'b1; tick();
        n_checks++; if (bus4.correct !== 1'b1) begin n_fail++; $display("FAIL midjudge_pre: got %b expected 1", bus4.correct); end
        rst_n = 1'b0; bus4.check = 1'b0;
        #1;
        n_checks++; if ({bus4.correct, bus4.wrong} !== 2'b00) begin n_fail++; $display("FAIL midjudge_discard: got %b expected 00", {bus4.correct, bus4.wrong}); end
        tick();
        n_checks++; if ({bus4.y, bus4.disp_a, bus4.disp_b, bus4.score, bus4.correct, bus4.wrong} !== 22'h0) begin n_fail++; $display("FAIL midjudge_outputs: got %h expected 0", {bus4.y, bus4.disp_a, bus4.disp_b, bus4.score, bus4.correct, bus4.wrong}); end
        rst_n = 1'b1; tick();
        n_checks++; if ({bus4.disp_a, bus4.disp_b} !== 8'hA5) begin n_fail++; $display("FAIL midjudge_lfsr_seed: got %h expected A5", {bus4.disp_a, bus4.disp_b}); end
    endtask

    task automatic test_ena_freeze();
        bus4.ena = 1'b0; bus4.check = 1'b1;
        repeat (3) tick();
        n_checks++; if ({bus4.correct, bus4.wrong, bus4.y} !== 6'h0) begin n_fail++; $display("FAIL ena_no_verdict: got %h expected 0", {bus4.correct, bus4.wrong, bus4.y}); end
        bus4.check = 1'b0; tick();
        bus4.ena = 1'b1; tick(); tick();
        n_checks++; if ({bus4.correct, bus4.wrong} !== 2'b00) begin n_fail++; $display("FAIL ena_resume_quiet: got %b expected 00", {bus4.correct, bus4.wrong}); end
        bus4.check = 1'b1; tick();
        n_checks++; if (bus4.correct !== 1'b1) begin n_fail++; $display("FAIL ena_new_edge: got %b expected 1", bus4.correct); end
        bus4.check = 1'b0; tick();
        n_checks++; if (bus4.score !== 8'd1) begin n_fail++; $display("FAIL ena_score: got %0d expected 1", bus4.score); end
    endtask
`else
    task automatic test_quiz_disabled();
        bus4.mode = 2'b10; bus4.a = 4'hC; bus4.b = 4'hA; bus4.sel = 3'b101; bus4.ans = 4'h6;
        tick();
        n_checks++; if (bus4.y !== 4'h6) begin n_fail++; $display("FAIL noquiz_live_y: got %h expected 6", bus4.y); end
        n_checks++; if ({bus4.disp_a, bus4.disp_b} !== 8'hCA) begin n_fail++; $display("FAIL noquiz_disp: got %h expected CA", {bus4.disp_a, bus4.disp_b}); end
        bus4.check = 1'b1; tick();
        n_checks++; if ({bus4.correct, bus4.wrong, bus4.score} !== 10'h0) begin n_fail++; $display("FAIL noquiz_tied: got %h expected 0", {bus4.correct, bus4.wrong, bus4.score}); end
        bus4.check = 1'b0; tick();
        n_checks++; if ({bus4.correct, bus4.wrong, bus4.score} !== 10'h0) begin n_fail++; $display("FAIL noquiz_tied_after: got %h expected 0", {bus4.correct, bus4.wrong, bus4.score}); end
    endtask
`endif

    initial begin
        bus4.ena = 1'b1; bus4.a = '0; bus4.b = '0; bus4.sel = '0; bus4.mode = '0;
        bus4.step = 1'b0; bus4.check = 1'b0; bus4.ans = '0;
        bus2.ena = 1'b1; bus2.a = '0; bus2.b = '0; bus2.sel = '0; bus2.mode = '0;
        bus2.step = 1'b0; bus2.check = 1'b0; bus2.ans = '0;
        test_reset();
        test_live();
        test_sweep();
`ifdef TRAINER_QUIZ_EN
        test_quiz();
        test_score_saturation();
        test_reset_mid_judge();
        test_ena_freeze();
`else
        test_quiz_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
